i2s_receiver: RTL and testbench



---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_sync_edge.sv | 42 ++++
 rtl/i2s_receiver.sv | 150 +++++++++++++++
 tb/tb_i2s_receiver.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receiver: FSM states, channel codes
// and the slot-counter width helper.
package i2s_pkg;

  typedef enum logic [1:0] {SEEK, SHIFT, SKIP} state_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  function automatic int cnt_width(input int slot_bits);
    return $clog2(slot_bits + 1);
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Synchronizes the asynchronous bclk/lrck/data pins into the clk domain and
// produces a single-cycle strobe on each synchronized bclk rising edge.
module i2s_sync_edge
  import i2s_pkg::*;
#(
  parameter int sync_stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i2s_bclk,
  input  logic i2s_lrck,
  input  logic i2s_data,
  output logic lrck_s,
  output logic data_s,
  output logic bclk_rise
);

  logic [sync_stages-1:0] bclk_sync;
  logic [sync_stages-1:0] lrck_sync;
  logic [sync_stages-1:0] data_sync;
  logic                   bclk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      data_sync <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[sync_stages-2:0], i2s_bclk};
      lrck_sync <= {lrck_sync[sync_stages-2:0], i2s_lrck};
      data_sync <= {data_sync[sync_stages-2:0], i2s_data};
      bclk_prev <= bclk_sync[sync_stages-1];
    end
  end

  // Data and lrck come from the same stage as the edge so they stay aligned.
  assign bclk_rise = bclk_sync[sync_stages-1] & ~bclk_prev;
  assign lrck_s    = lrck_sync[sync_stages-1];
  assign data_s    = data_sync[sync_stages-1];

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S deserializer producing signed L/R PCM pairs with a ready strobe.
// Optional slot-length checking is built when I2S_RX_FRAME_CHECK_EN is defined.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int bits        = 16,
  parameter int slot_bits   = 32,
  parameter int sync_stages = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i2s_bclk,
  input  logic                   i2s_lrck,
  input  logic                   i2s_data,
  output logic signed [bits-1:0] sample_l,
  output logic signed [bits-1:0] sample_r,
  output logic                   sample_ready,
  output logic                   frame_err
);

  localparam int IDX_W = $clog2(bits);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(bits - 1);

  logic             lrck_s;
  logic             data_s;
  logic             bclk_rise;
  logic             transition;
  logic [bits-1:0]  word_next;

  state_t           state;
  logic             lrck_hist;
  logic             slot_chan;
  logic [IDX_W-1:0] bit_idx;
  logic [bits-1:0]  shreg;
  logic [bits-1:0]  hold_l;
  logic [bits-1:0]  hold_r;
  logic             left_valid;
  logic             right_done;

  i2s_sync_edge #(.sync_stages(sync_stages)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrck  (i2s_lrck),
    .i2s_data  (i2s_data),
    .lrck_s    (lrck_s),
    .data_s    (data_s),
    .bclk_rise (bclk_rise)
  );

  assign transition = bclk_rise && (lrck_s != lrck_hist);
  assign word_next  = {shreg[bits-2:0], data_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SEEK;
      lrck_hist    <= 1'b0;
      slot_chan    <= LEFT;
      bit_idx      <= '0;
      shreg        <= '0;
      hold_l       <= '0;
      hold_r       <= '0;
      left_valid   <= 1'b0;
      right_done   <= 1'b0;
      sample_l     <= '0;
      sample_r     <= '0;
      sample_ready <= 1'b0;
    end else begin
      right_done   <= 1'b0;
      sample_ready <= 1'b0;
      if (bclk_rise) begin
        lrck_hist <= lrck_s;
        case (state)
          SEEK, SKIP: begin
            if (transition) begin
              state     <= SHIFT;
              bit_idx   <= '0;
              slot_chan <= lrck_s;
            end
          end
          SHIFT: begin
            // A word finishing on the closing transition still counts as complete.
            if (bit_idx == LAST_IDX) begin
              shreg   <= word_next;
              bit_idx <= '0;
              if (slot_chan == LEFT) begin
                hold_l     <= word_next;
                left_valid <= 1'b1;
              end else begin
                hold_r     <= word_next;
                right_done <= 1'b1;
              end
              if (transition) begin
                state     <= SHIFT;
                slot_chan <= lrck_s;
              end else begin
                state <= SKIP;
              end
            end else if (transition) begin
              left_valid <= 1'b0;
              bit_idx    <= '0;
              slot_chan  <= lrck_s;
            end else begin
              shreg   <= word_next;
              bit_idx <= bit_idx + 1'b1;
            end
          end
          default: state <= SEEK;
        endcase
      end
      if (right_done && left_valid) begin
        sample_l     <= hold_l;
        sample_r     <= hold_r;
        sample_ready <= 1'b1;
        left_valid   <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  localparam int CNT_W = cnt_width(slot_bits);

  logic [CNT_W-1:0] slot_cnt;
  logic             check_armed;

  // The first slot after SEEK is unarmed because its start was never observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      check_armed <= 1'b0;
      frame_err   <= 1'b0;
    end else if (bclk_rise) begin
      if (state == SEEK) begin
        slot_cnt    <= '0;
        check_armed <= 1'b0;
      end else if (transition) begin
        if (check_armed && (({1'b0, slot_cnt} + 1'b1) != (CNT_W + 1)'(slot_bits)))
          frame_err <= 1'b1;
        check_armed <= 1'b1;
        slot_cnt    <= '0;
      end else if (slot_cnt != {CNT_W{1'b1}}) begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: a slot-level model predicts L/R pairs,
// a negedge monitor compares every strobe, its latency and the held outputs.
module tb_i2s_receiver;

  localparam int BITS = 16;
  localparam int SLOT = 32;
  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i2s_bclk = 1'b0;
  logic            i2s_lrck = 1'b0;
  logic            i2s_data = 1'b0;
  logic [BITS-1:0] sample_l;
  logic [BITS-1:0] sample_r;
  logic            sample_ready;
  logic            frame_err;

  i2s_receiver #(.bits(BITS), .slot_bits(SLOT), .sync_stages(SYNC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_data     (i2s_data),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_ready (sample_ready),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BITS-1:0] l;
    logic [BITS-1:0] r;
    int              edge_cyc;
  } pair_t;

  typedef struct {
    bit          chan;
    int          len;
    logic [63:0] word;
    int          wbits;
  } slot_t;

  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;
  int              strobes = 0;
  pair_t           exp_q[$];
  pair_t           mon_e;
  slot_t           slots[$];
  logic [BITS-1:0] hold_l = '0;
  logic [BITS-1:0] hold_r = '0;
  logic            ready_prev = 1'b0;
  bit              exp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops one expected pair per strobe; outputs must hold otherwise.
  always @(negedge clk) begin
    if (sample_ready) begin
      strobes++;
      checkOutput("strobe_width", 64'(ready_prev), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_strobe actual=L0x%0h/R0x%0h expected=no strobe at cycle %0d",
                 sample_l, sample_r, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sample_l", 64'(sample_l), 64'(mon_e.l));
        checkOutput("sample_r", 64'(sample_r), 64'(mon_e.r));
        checkOutput("latency", 64'(cyc - mon_e.edge_cyc), 64'(SYNC + 2));
        hold_l = mon_e.l;
        hold_r = mon_e.r;
      end
    end else begin
      checkOutput("hold_l", 64'(sample_l), 64'(hold_l));
      checkOutput("hold_r", 64'(sample_r), 64'(hold_r));
    end
    ready_prev = sample_ready;
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    hold_l   = '0;
    hold_r   = '0;
    i2s_bclk = 1'b0;
    i2s_lrck = 1'b0;
    i2s_data = 1'b0;
    exp_err  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic add_slot(input bit chan, input int len, input logic [63:0] word, input int wbits);
    slot_t s;
    s.chan  = chan;
    s.len   = len;
    s.word  = word;
    s.wbits = wbits;
    slots.push_back(s);
  endtask

  // Slot-level model then pin driver; rst_slot >= 0 pulses reset after that
  // slot's word has been captured.
  task automatic applyStimulus(input int rst_slot);
    bit              lr[$];
    bit              dt[$];
    bit              flag[$];
    pair_t           pairs[$];
    pair_t           p;
    bit              pend = 1'b0;
    bit              armed = 1'b0;
    logic [BITS-1:0] lw = '0;
    logic [BITS-1:0] w;
    int              start;
    int              rst_idx = -1;
    int              mi = 0;

    for (int k = 0; k < slots.size(); k++) begin
      start = lr.size();
      for (int b = 0; b < slots[k].len; b++) begin
        dt.push_back((b < slots[k].wbits) ? slots[k].word[slots[k].wbits - 1 - b] : 1'b0);
        lr.push_back((b == slots[k].len - 1 && k + 1 < slots.size()) ? slots[k + 1].chan : slots[k].chan);
        flag.push_back(1'b0);
      end
      if (k > 0) begin
        if (slots[k].len >= BITS) begin
          for (int b = 0; b < BITS; b++) w[BITS - 1 - b] = dt[start + b];
          if (slots[k].chan == 1'b0) begin
            pend = 1'b1;
            lw   = w;
          end else if (pend) begin
            p.l = lw;
            p.r = w;
            p.edge_cyc = 0;
            pairs.push_back(p);
            flag[start + BITS - 1] = 1'b1;
            pend = 1'b0;
          end
        end else begin
          pend = 1'b0;
        end
      end
      if (k == rst_slot) begin
        pend    = 1'b0;
        armed   = 1'b0;
        exp_err = 1'b0;
        rst_idx = start + BITS + 2;
      end else if (k + 1 < slots.size()) begin
        if (armed && slots[k].len != SLOT) exp_err = 1'b1;
        armed = 1'b1;
      end
    end

    for (int i = 0; i < lr.size(); i++) begin
      @(posedge clk);
      #1;
      i2s_bclk = 1'b0;
      i2s_lrck = lr[i];
      i2s_data = dt[i];
      if (i == rst_idx) begin
        @(posedge clk);
        #1 rst_n = 1'b0;
        hold_l = '0;
        hold_r = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (HALF - 3) @(posedge clk);
      end else begin
        repeat (HALF - 1) @(posedge clk);
      end
      #1 i2s_bclk = 1'b1;
      if (flag[i]) begin
        p = pairs[mi];
        mi++;
        p.edge_cyc = cyc;
        exp_q.push_back(p);
      end
      repeat (HALF - 1) @(posedge clk);
    end
    @(posedge clk);
    #1 i2s_bclk = 1'b0;

    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(posedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
`ifdef I2S_RX_FRAME_CHECK_EN
    checkOutput("frame_err", 64'(frame_err), 64'(exp_err));
`else
    checkOutput("frame_err", 64'(frame_err), 64'd0);
`endif
    slots.delete();
  endtask

  int len;

  initial begin
    do_reset();
    @(negedge clk);
    checkOutput("reset_sample_l", 64'(sample_l), 64'd0);
    checkOutput("reset_sample_r", 64'(sample_r), 64'd0);
    checkOutput("reset_ready", 64'(sample_ready), 64'd0);
    checkOutput("reset_frame_err", 64'(frame_err), 64'd0);
    repeat (100) @(posedge clk);
    checkOutput("idle_strobes", 64'(strobes), 64'd0);

    $display("[TB] two fixed frames, stream starts mid right slot");
    do_reset();
    add_slot(1'b1, 12, 64'h5A5A, 16);
    add_slot(1'b0, SLOT, 64'h1234, 16);
    add_slot(1'b1, SLOT, 64'h8001, 16);
    add_slot(1'b0, SLOT, 64'h1234, 16);
    add_slot(1'b1, SLOT, 64'h8001, 16);
    applyStimulus(-1);

    $display("[TB] 24-bit words truncated");
    do_reset();
    add_slot(1'b1, 20, 64'hFFFFF, 20);
    add_slot(1'b0, SLOT, 64'h7FFFAB, 24);
    add_slot(1'b1, SLOT, 64'h800012, 24);
    applyStimulus(-1);

    $display("[TB] short left slot");
    do_reset();
    add_slot(1'b1, 12, 64'h0, 16);
    add_slot(1'b0, SLOT, 64'hA5C3, 16);
    add_slot(1'b1, SLOT, 64'h3C5A, 16);
    add_slot(1'b0, 10, 64'hFFFF, 16);
    add_slot(1'b1, SLOT, 64'h1111, 16);
    add_slot(1'b0, SLOT, 64'h2222, 16);
    add_slot(1'b1, SLOT, 64'hEEEE, 16);
    applyStimulus(-1);

    $display("[TB] reset after left word");
    do_reset();
    add_slot(1'b1, 12, 64'h0, 16);
    add_slot(1'b0, SLOT, 64'hBEEF, 16);
    add_slot(1'b1, SLOT, 64'hCAFE, 16);
    add_slot(1'b0, SLOT, 64'h0F0F, 16);
    add_slot(1'b1, SLOT, 64'hF00D, 16);
    applyStimulus(1);

    $display("[TB] randomized streams");
    for (int s = 0; s < 3; s++) begin
      do_reset();
      add_slot(1'b1, $urandom_range(4, 24), {32'h0, $urandom}, 16);
      for (int k = 0; k < 6; k++) begin
        len = ($urandom_range(0, 9) < 7) ? SLOT : $urandom_range(8, 40);
        add_slot(k[0], len, {$urandom, $urandom}, $urandom_range(16, 24));
      end
      applyStimulus(-1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
